quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter N, default 8: width of position count.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port a, b  input  1 each  quadrature encoder channels, asynchronous to clk.
REQ-005 Port en  input  1  count enable.
REQ-006 Port syn_clr  input  1  synchronous clear of position.
REQ-007 Port load  input  1  synchronous load of position from d.
REQ-008 Port d  input  N  load value.
REQ-009 Port err_clr  input  1  clears sticky error flag.
REQ-010 Port q  output  N  current position count.
REQ-011 Port step  output  1  one-cycle pulse per counted quadrature step.
REQ-012 Port dir  output  1  direction of last counted step; 1 = up.
REQ-013 Port max_tick, min_tick  output  1 each  q == 2^N-1, q == 0 (combinational from q).
REQ-014 Port err  output  1  sticky illegal-transition flag.

Function
REQ-015 a, b SHALL pass through a two-flop synchronizer; the second stage forms the current phase {a,b}.
REQ-016 A phase register SHALL hold the previous synchronized phase and update every cycle after priming.
REQ-017 Forward sequence 00->01->11->10->00 SHALL decode as up; reverse sequence as down.
REQ-018 No phase change SHALL decode as idle: no step, q unchanged (except clr/load).
REQ-019 Both bits changing in one cycle (00<->11, 01<->10) SHALL decode as illegal: no count, no step, err set.
REQ-020 Position priority SHALL be syn_clr > load > decoded step; clr/load apply regardless of en.
REQ-021 When en=1 and no clr/load, up SHALL make q = q+1 and down q = q-1, modulo 2^N.
REQ-022 Wrap: up from 2^N-1 SHALL give 0; down from 0 SHALL give 2^N-1.
REQ-023 step SHALL be a registered pulse high exactly one cycle for each legal up/down decode with en=1, including when clr/load overrides the count.
REQ-024 dir SHALL be registered with step and hold its value between steps.
REQ-025 With en=0, phase tracking and err detection SHALL continue; step stays 0, q changes only via clr/load.
REQ-026 Latency: an a/b change stable before edge E SHALL produce updated q and step=1 after edge E+2.
REQ-027 err SHALL remain 1 until err_clr; if an illegal decode and err_clr coincide, err SHALL be 1.
REQ-028 A primed flag SHALL be 0 after reset; the first cycle with primed=0 loads the phase register from the synchronizer without decoding, then sets primed.

Reset
REQ-029 With rst=1 at a clock edge: q=0, step=0, dir=0, err=0, primed=0, synchronizer and phase registers = 00.
REQ-030 Reset mid-step SHALL discard any in-flight transition; no step pulse after reset release until a new legal transition is observed post-priming.
REQ-031 No spurious err or count SHALL occur after reset release regardless of a/b level.

Structure
REQ-032 Package quad_dec_pkg SHALL hold phase encodings (PH_00, PH_01, PH_11, PH_10) and decode result constants (DEC_IDLE, DEC_UP, DEC_DOWN, DEC_ERR).
REQ-033 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, instantiated per channel); decode, counter and flag logic remain in quad_decoder.

Verification
REQ-034 Reset, then four forward phases 00->01->11->10->00 each held 4 cycles, en=1 -> q=4, four step pulses, dir=1, err=0.
REQ-035 N=8, load d=255, one forward step -> q=0, min_tick=1; one reverse step -> q=255, max_tick=1, dir=0.
REQ-036 Phase 00 jumps to 11 -> err=1, q unchanged, no step; err_clr asserted on same cycle as a second illegal jump -> err stays 1.
REQ-037 a/b held at 11 through reset release -> no err, q=0, no step; subsequent 11->10 -> q=1.
REQ-038 syn_clr and a legal up decode in the same cycle with q=7 -> q=0, step=1, dir=1; en=0 during three steps -> q unchanged, step=0.

Source files
------------

// File: rtl/quad_dec_pkg.sv
// quad_dec_pkg
//   Shared definitions for the quadrature decoder: the four phase encodings
//   of the {a,b} channel pair, the decode result type, and the transition
//   decode function used by quad_decoder.
package quad_dec_pkg;

  // Phase encodings, listed in forward (count-up) order.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DOWN = 2'd2,
    DEC_ERR  = 2'd3
  } dec_t;

  // Classify one phase transition. Any change of both bits at once is
  // illegal because the true order of the two edges cannot be recovered.
  function automatic dec_t decode_phase(input logic [1:0] prev_ph,
                                        input logic [1:0] cur_ph);
    dec_t res;
    res = DEC_ERR;
    if (prev_ph == cur_ph) begin
      res = DEC_IDLE;
    end else begin
      case (prev_ph)
        PH_00:   res = (cur_ph == PH_01) ? DEC_UP : (cur_ph == PH_10) ? DEC_DOWN : DEC_ERR;
        PH_01:   res = (cur_ph == PH_11) ? DEC_UP : (cur_ph == PH_00) ? DEC_DOWN : DEC_ERR;
        PH_11:   res = (cur_ph == PH_10) ? DEC_UP : (cur_ph == PH_01) ? DEC_DOWN : DEC_ERR;
        default: res = (cur_ph == PH_00) ? DEC_UP : (cur_ph == PH_11) ? DEC_DOWN : DEC_ERR;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for one asynchronous bit.
//   Ports: clk - clock; rst - synchronous active-high reset (clears both
//   stages); d - asynchronous input; q - synchronized output (second stage).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder
//   Quadrature encoder decoder with an N-bit position counter.
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     a, b              - asynchronous encoder channels
//     en                - count enable (clear/load ignore it)
//     syn_clr, load, d  - synchronous clear / load of the position
//     err_clr           - clears the sticky illegal-transition flag
//     q                 - position count
//     step, dir         - one-cycle pulse per counted step, its direction (1 = up)
//     max_tick, min_tick- q is all ones / q is zero
//     err               - sticky illegal-transition flag
module quad_decoder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         b,
  input  logic         en,
  input  logic         syn_clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         err_clr,
  output logic [N-1:0] q,
  output logic         step,
  output logic         dir,
  output logic         max_tick,
  output logic         min_tick,
  output logic         err
);

  import quad_dec_pkg::*;

  logic [1:0]   ab_raw;
  logic [1:0]   ph_cur;
  logic [1:0]   ph_reg,     ph_next;
  logic [1:0]   warm_reg,   warm_next;
  logic         primed_reg, primed_next;
  logic [N-1:0] q_reg,      q_next;
  logic         step_reg,   step_next;
  logic         dir_reg,    dir_next;
  logic         err_reg,    err_next;
  dec_t         dec;

  assign ab_raw = {a, b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ab_raw[gi]),
        .q   (ph_cur[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_reg     <= PH_00;
      warm_reg   <= 2'b00;
      primed_reg <= 1'b0;
      q_reg      <= '0;
      step_reg   <= 1'b0;
      dir_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      ph_reg     <= ph_next;
      warm_reg   <= warm_next;
      primed_reg <= primed_next;
      q_reg      <= q_next;
      step_reg   <= step_next;
      dir_reg    <= dir_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    ph_next     = ph_cur;
    // The synchronizer restarts from 00, so its output only reflects the
    // real channel level two cycles after reset. Priming waits for that
    // (warm_reg) so a stationary non-00 input is not seen as a transition.
    warm_next   = {warm_reg[0], 1'b1};
    primed_next = primed_reg | warm_reg[1];
    dec         = primed_reg ? decode_phase(ph_reg, ph_cur) : DEC_IDLE;

    step_next   = en && ((dec == DEC_UP) || (dec == DEC_DOWN));
    dir_next    = step_next ? (dec == DEC_UP) : dir_reg;

    q_next = q_reg;
    if (syn_clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = d;
    end else if (step_next) begin
      q_next = (dec == DEC_UP) ? q_reg + 1'b1 : q_reg - 1'b1;
    end

    // A new illegal decode wins over a simultaneous clear.
    err_next = (err_reg && !err_clr) || (dec == DEC_ERR);
  end

  assign q        = q_reg;
  assign step     = step_reg;
  assign dir      = dir_reg;
  assign err      = err_reg;
  assign max_tick = &q_reg;
  assign min_tick = (q_reg == '0);

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder
//   Self-checking bench for quad_decoder (N = 8). Table-driven phase walk
//   plus hand-written corner sequences; every counted step is checked by a
//   scoreboard queue filled when the phase change is driven.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0;
  logic       en = 1'b0, syn_clr = 1'b0, load = 1'b0, err_clr = 1'b0;
  logic [7:0] d = 8'd0;
  logic [7:0] q;
  logic       step, dir, max_tick, min_tick, err;

  quad_decoder #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .en       (en),
    .syn_clr  (syn_clr),
    .load     (load),
    .d        (d),
    .err_clr  (err_clr),
    .q        (q),
    .step     (step),
    .dir      (dir),
    .max_tick (max_tick),
    .min_tick (min_tick),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic       dir;
  } exp_t;

  typedef struct {
    logic [1:0] ph;
    logic       en;
    logic [7:0] q;
    logic       dir;
    logic       err;
  } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] model_ph = 2'b00;
  logic [7:0] exp_q = 8'd0;
  logic       exp_dir = 1'b0;
  logic       exp_err = 1'b0;
  vec_t       vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Position in the forward cycle 00,01,11,10.
  function automatic int ph_idx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Scoreboard: every step pulse must match the oldest expected step.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: step=1 q=%0d, expected no step at %0t", q, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("step_q", {24'd0, q}, {24'd0, mon_e.q});
        chk("step_dir", {31'd0, dir}, {31'd0, mon_e.dir});
      end
    end
  end

  // ctl: 0 = plain, 1 = syn_clr on the decode edge, 2 = err_clr on the decode edge.
  task automatic drive_phase(input logic [1:0] ph, input int ctl);
    int delta;
    @(negedge clk);
    a = ph[1];
    b = ph[0];
    delta = (ph_idx(ph) - ph_idx(model_ph) + 4) % 4;
    model_ph = ph;
    if (ctl == 1) exp_q = 8'd0;
    if (delta == 2) begin
      exp_err = 1'b1;
    end else if (delta != 0 && en) begin
      if (ctl != 1) exp_q = (delta == 1) ? exp_q + 8'd1 : exp_q - 8'd1;
      exp_dir = (delta == 1);
      sb.push_back({exp_q, exp_dir});
    end
    repeat (2) @(negedge clk);
    if (ctl == 1) syn_clr = 1'b1;
    if (ctl == 2) err_clr = 1'b1;
    @(negedge clk);
    syn_clr = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_q"}, {24'd0, q}, {24'd0, exp_q});
    chk({tag, "_dir"}, {31'd0, dir}, {31'd0, exp_dir});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_min"}, {31'd0, min_tick}, {31'd0, (exp_q == 8'd0)});
    chk({tag, "_max"}, {31'd0, max_tick}, {31'd0, (exp_q == 8'd255)});
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    a = ab[1];
    b = ab[0];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    model_ph = ab;
    exp_q = 8'd0;
    exp_dir = 1'b0;
    exp_err = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    load = 1'b1;
    d = v;
    @(negedge clk);
    load = 1'b0;
    exp_q = v;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 1'b1, 8'd1, 1'b1, 1'b0};
    vecs[1]  = '{2'b11, 1'b1, 8'd2, 1'b1, 1'b0};
    vecs[2]  = '{2'b10, 1'b1, 8'd3, 1'b1, 1'b0};
    vecs[3]  = '{2'b00, 1'b1, 8'd4, 1'b1, 1'b0};
    vecs[4]  = '{2'b10, 1'b1, 8'd3, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, 1'b1, 8'd2, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 8'd2, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 1'b0, 8'd2, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 8'd2, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 1'b0, 8'd2, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 1'b1, 8'd3, 1'b1, 1'b0};

    do_reset(2'b00);
    check_state("post_reset");

    // Forward/reverse walk, idle, and enable-off steps.
    for (int i = 0; i < 11; i++) begin
      en = vecs[i].en;
      drive_phase(vecs[i].ph, 0);
      chk($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, vecs[i].q});
      chk($sformatf("vec%0d_dir", i), {31'd0, dir}, {31'd0, vecs[i].dir});
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
    end
    en = 1'b1;

    // Wrap at both ends.
    do_load(8'd255);
    check_state("load255");
    drive_phase(2'b10, 0);
    check_state("wrap_up");
    drive_phase(2'b11, 0);
    check_state("wrap_down");

    // Illegal jump, stickiness, clear, and clear coinciding with a new illegal.
    drive_phase(2'b00, 0);
    check_state("illegal1");
    repeat (5) @(negedge clk);
    check_state("err_sticky");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check_state("err_cleared");
    drive_phase(2'b11, 2);
    check_state("illegal_vs_clr");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check_state("err_cleared2");

    // Clear overrides a legal up decode but the step still pulses.
    do_load(8'd7);
    check_state("load7");
    drive_phase(2'b10, 1);
    check_state("clr_with_step");

    // Inputs parked at 11 through reset release.
    do_reset(2'b11);
    check_state("reset_at_11");
    drive_phase(2'b10, 0);
    check_state("after_11_up");

    // Reset while a transition is still in the synchronizer.
    @(negedge clk);
    a = 1'b0;
    b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ph = 2'b00;
    exp_q = 8'd0;
    exp_dir = 1'b0;
    exp_err = 1'b0;
    repeat (8) @(negedge clk);
    check_state("mid_step_reset");
    drive_phase(2'b01, 0);
    check_state("after_mid_reset");

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
